// File: rtl/regfile_wb_pkg.sv
// Shared register-file constants used by writeback, exception logic and the
// architectural register file.
package regfile_wb_pkg;

    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int IDX_W = 5;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO    = 5'd0;
    localparam reg_idx_t REG_RSTATUS = 5'd30;
    localparam reg_idx_t REG_RA      = 5'd31;

    localparam logic [WIDTH-1:0] RSTATUS_ADD  = 32'd1;
    localparam logic [WIDTH-1:0] RSTATUS_ADDI = 32'd2;
    localparam logic [WIDTH-1:0] RSTATUS_SUB  = 32'd3;

endpackage

// File: rtl/regfile_wb_if.sv
// Writeback/decode-facing bus of the register file: one write port and two
// combinational read ports.
interface regfile_wb_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
);
    logic             ctrl_writeEnable;
    logic [IDX_W-1:0] ctrl_writeReg;
    logic [WIDTH-1:0] data_writeReg;
    logic [IDX_W-1:0] ctrl_readRegA;
    logic [IDX_W-1:0] ctrl_readRegB;
    logic [WIDTH-1:0] data_readRegA;
    logic [WIDTH-1:0] data_readRegB;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB
    );
endinterface

// File: rtl/regfile_wb_register_row.sv
// One architectural register: WIDTH flops with write enable and synchronous
// active-high clear.
module register_row #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Row storage; reset wins over a simultaneous write.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file: 31 writable rows plus hard-wired r0, one
// synchronous write port and two combinational read ports with optional bypass.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int WIDTH  = regfile_wb_pkg::WIDTH,
    parameter int NREGS  = regfile_wb_pkg::NREGS,
    parameter int BYPASS = 1
) (
    input  logic        clock,
    input  logic        reset,
    regfile_wb_if.slave bus
);

    localparam int IDX_W = $clog2(NREGS);

    logic [NREGS-1:0] w_dec;
    logic [WIDTH-1:0] w_rows  [NREGS];
    logic [WIDTH-1:0] w_sel_a [NREGS];
    logic [WIDTH-1:0] w_sel_b [NREGS];
    logic [WIDTH-1:0] w_stored_a;
    logic [WIDTH-1:0] w_stored_b;
    logic             w_byp_a;
    logic             w_byp_b;

    assign w_dec[0]  = 1'b0;
    assign w_rows[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_row
            assign w_dec[gi] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == IDX_W'(gi));

            register_row #(.WIDTH(WIDTH)) u_row (
                .clock (clock),
                .reset (reset),
                .i_en  (w_dec[gi]),
                .i_d   (bus.data_writeReg),
                .o_q   (w_rows[gi])
            );
        end

        // AND-OR read mux: each row is masked by its own index match.
        for (gi = 0; gi < NREGS; gi++) begin : g_rdmask
            assign w_sel_a[gi] = (bus.ctrl_readRegA == IDX_W'(gi)) ? w_rows[gi] : '0;
            assign w_sel_b[gi] = (bus.ctrl_readRegB == IDX_W'(gi)) ? w_rows[gi] : '0;
        end
    endgenerate

    // Collapse the masked rows into the stored value seen by each port.
    always_comb begin
        w_stored_a = '0;
        w_stored_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_stored_a = w_stored_a | w_sel_a[i];
            w_stored_b = w_stored_b | w_sel_b[i];
        end
    end

    assign w_byp_a = (BYPASS != 0) && bus.ctrl_writeEnable && !reset &&
                     (bus.ctrl_writeReg == bus.ctrl_readRegA) &&
                     (bus.ctrl_readRegA != REG_ZERO);
    assign w_byp_b = (BYPASS != 0) && bus.ctrl_writeEnable && !reset &&
                     (bus.ctrl_writeReg == bus.ctrl_readRegB) &&
                     (bus.ctrl_readRegB != REG_ZERO);

    assign bus.data_readRegA = w_byp_a ? bus.data_writeReg : w_stored_a;
    assign bus.data_readRegB = w_byp_b ? bus.data_writeReg : w_stored_b;

endmodule

// File: tb/tb_regfile_wb.sv
// Scoreboard bench driving a bypassing and a non-bypassing register file with
// identical directed stimulus.
module tb_regfile_wb;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    logic clock;
    logic reset;

    regfile_wb_if #(.WIDTH(32), .IDX_W(5)) if_b ();
    regfile_wb_if #(.WIDTH(32), .IDX_W(5)) if_n ();

    regfile_wb #(.WIDTH(32), .NREGS(32), .BYPASS(1)) dut_b (
        .clock (clock), .reset (reset), .bus (if_b.slave)
    );
    regfile_wb #(.WIDTH(32), .NREGS(32), .BYPASS(0)) dut_n (
        .clock (clock), .reset (reset), .bus (if_n.slave)
    );

    chk_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            0:       return if_b.data_readRegA;
            1:       return if_b.data_readRegB;
            2:       return if_n.data_readRegA;
            3:       return if_n.data_readRegB;
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: outputs are combinational and valid every cycle, so every queued
    // expectation is retired at the falling edge of the cycle it was issued in.
    always @(negedge clock) begin
        while (sb_q.size() > 0) begin
            chk_t c;
            logic [31:0] act;
            c   = sb_q.pop_front();
            act = get_out(c.sel);
            n_checks++;
            if (act === c.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s port%0d: got %08h expected %08h", c.name, c.sel, act, c.exp);
            end
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] wr,
                         input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clock);
        #1;
        reset = rst;
        if_b.ctrl_writeEnable = we; if_n.ctrl_writeEnable = we;
        if_b.ctrl_writeReg    = wr; if_n.ctrl_writeReg    = wr;
        if_b.data_writeReg    = wd; if_n.data_writeReg    = wd;
        if_b.ctrl_readRegA    = ra; if_n.ctrl_readRegA    = ra;
        if_b.ctrl_readRegB    = rb; if_n.ctrl_readRegB    = rb;
    endtask

    task automatic expect4(input string name, input logic [31:0] ba, input logic [31:0] bb,
                           input logic [31:0] na, input logic [31:0] nb);
        sb_q.push_back('{name: name, sel: 0, exp: ba});
        sb_q.push_back('{name: name, sel: 1, exp: bb});
        sb_q.push_back('{name: name, sel: 2, exp: na});
        sb_q.push_back('{name: name, sel: 3, exp: nb});
    endtask

    initial begin
        int wait_cyc;
        reset = 1'b1;
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            expect4("reset_read", 32'h0, 32'h0, 32'h0, 32'h0);
        end

        drive(1'b0, 1'b1, 5'd30, 32'h0000_0001, 5'd29, 5'd0);
        expect4("r30_wr", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd30, 5'd29);
        expect4("r30_rd", 32'h1, 32'h0, 32'h1, 32'h0);

        drive(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd0);
        expect4("r0_wr_byp", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd30);
        expect4("r0_rd", 32'h0, 32'h1, 32'h0, 32'h1);

        drive(1'b0, 1'b1, 5'd31, 32'h0000_0005, 5'd31, 5'd31);
        expect4("r31_byp", 32'h5, 32'h5, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31);
        expect4("r31_stored", 32'h5, 32'h5, 32'h5, 32'h5);

        drive(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd31);
        expect4("r7_wr", 32'h1234_5678, 32'h5, 32'h0, 32'h5);
        drive(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 5'd7, 5'd31);
        expect4("rst_cycle", 32'h1234_5678, 32'h5, 32'h1234_5678, 32'h5);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
        expect4("post_rst", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd30, 5'd1);
        expect4("post_rst2", 32'h0, 32'h0, 32'h0, 32'h0);

        drive(1'b0, 1'b1, 5'd5, 32'hAAAA_0000, 5'd5, 5'd7);
        expect4("b2b_1", 32'hAAAA_0000, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 5'd5, 32'h0000_BBBB, 5'd5, 5'd7);
        expect4("b2b_2", 32'h0000_BBBB, 32'h0, 32'hAAAA_0000, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        expect4("b2b_3", 32'h0000_BBBB, 32'h0000_BBBB, 32'h0000_BBBB, 32'h0000_BBBB);

        drive(1'b0, 1'b1, 5'd12, 32'h0000_0C0C, 5'd12, 5'd5);
        expect4("byp_one_port", 32'h0000_0C0C, 32'h0000_BBBB, 32'h0, 32'h0000_BBBB);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
        expect4("r12_rd", 32'h0000_0C0C, 32'h0000_0C0C, 32'h0000_0C0C, 32'h0000_0C0C);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd6);
        expect4("neighbours", 32'h0, 32'h0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd13, 5'd11);
        expect4("neighbours2", 32'h0, 32'h0, 32'h0, 32'h0);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clock);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            $display("FAIL drain: %0d checks left, expected 0", sb_q.size());
            n_checks += sb_q.size();
        end
        @(posedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
